// File: rtl/udp_rx_to_buff_if.sv
// Header and payload-stream bundle between the UDP/IP core (master) and the RX buffer feeder (slave).
interface udp_rx_to_buff_if;
  logic        HDR_VALID;
  logic        HDR_READY;
  logic [0:31] HDR_SRC_IP;
  logic [0:47] HDR_SRC_MAC;
  logic [0:15] HDR_SRC_UDP_PORT;
  logic [0:15] HDR_DST_UDP_PORT;
  logic [7:0]  S_TDATA;
  logic        S_TVALID;
  logic        S_TLAST;
  logic        S_TREADY;

  modport master (
    output HDR_VALID, HDR_SRC_IP, HDR_SRC_MAC, HDR_SRC_UDP_PORT, HDR_DST_UDP_PORT,
    output S_TDATA, S_TVALID, S_TLAST,
    input  HDR_READY, S_TREADY
  );

  modport slave (
    input  HDR_VALID, HDR_SRC_IP, HDR_SRC_MAC, HDR_SRC_UDP_PORT, HDR_DST_UDP_PORT,
    input  S_TDATA, S_TVALID, S_TLAST,
    output HDR_READY, S_TREADY
  );
endinterface

// File: rtl/udp_rx_to_buff.sv
// Filters UDP frames by destination port and exact length, writes the payload into the RX buffer
// and hands the buffer to the downstream stage, holding off new frames until it reports done.
module udp_rx_to_buff #(
  parameter int          USER_DATA_BYTES = 784,
  parameter int          ADDR_W          = 10,
  parameter logic [15:0] LISTEN_PORT     = 16'd9000
) (
  input  logic              ACLK,
  input  logic              ARESET,
  udp_rx_to_buff_if.slave   s_if,
  output logic [7:0]        RX_DATA,
  output logic [ADDR_W-1:0] RX_ADDR,
  output logic              RX_EN,
  output logic [0:31]       SRC_IP_ADDRESS_IP,
  output logic [0:47]       SRC_MAC_ADDRESS_IP,
  output logic [0:15]       SRC_UDP_PORT_IP,
  output logic              FRAME_READY,
  input  logic              BUFF_DONE,
  output logic [15:0]       DROP_COUNT
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(USER_DATA_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_DROP,
    ST_READY,
    ST_WAIT_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [ADDR_W-1:0] r_count;
  logic [0:31]       r_shadow_ip;
  logic [0:47]       r_shadow_mac;
  logic [0:15]       r_shadow_port;
  logic [7:0]        r_rx_data;
  logic [ADDR_W-1:0] r_rx_addr;
  logic              r_rx_en;
  logic [0:31]       r_src_ip;
  logic [0:47]       r_src_mac;
  logic [0:15]       r_src_port;
  logic [15:0]       r_drop_count;

  logic              w_hdr_fire;
  logic              w_beat;
  logic              w_write;
  logic              w_load_hdr;
  logic              w_latch_src;
  logic              w_drop_inc;

  // Readies are gated by reset so every output reads 0 while reset is held.
  assign s_if.HDR_READY = ARESET && (r_state == ST_IDLE);
  assign s_if.S_TREADY  = ARESET && ((r_state == ST_RECV) || (r_state == ST_DROP));

  assign w_hdr_fire = s_if.HDR_VALID && s_if.HDR_READY;
  assign w_beat     = s_if.S_TVALID && s_if.S_TREADY;

  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_write      = 1'b0;
    w_load_hdr   = 1'b0;
    w_latch_src  = 1'b0;
    w_drop_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hdr_fire) begin
          if (s_if.HDR_DST_UDP_PORT == LISTEN_PORT) begin
            w_state_next = ST_RECV;
            w_load_hdr   = 1'b1;
          end else begin
            w_state_next = ST_DROP;
            w_drop_inc   = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (w_beat) begin
          w_write = 1'b1;
          if (r_count == LAST_ADDR) begin
            if (s_if.S_TLAST) begin
              w_state_next = ST_READY;
              w_latch_src  = 1'b1;
            end else begin
              // Too long: buffer is full, drain the remainder without writing.
              w_state_next = ST_DROP;
              w_drop_inc   = 1'b1;
            end
          end else if (s_if.S_TLAST) begin
            w_state_next = ST_IDLE;
            w_drop_inc   = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (w_beat && s_if.S_TLAST) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_READY: begin
        w_state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (BUFF_DONE) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      r_count       <= '0;
      r_shadow_ip   <= '0;
      r_shadow_mac  <= '0;
      r_shadow_port <= '0;
      r_rx_data     <= '0;
      r_rx_addr     <= '0;
      r_rx_en       <= 1'b0;
      r_src_ip      <= '0;
      r_src_mac     <= '0;
      r_src_port    <= '0;
      r_drop_count  <= '0;
    end else begin
      r_rx_en <= w_write;
      if (w_write) begin
        r_rx_data <= s_if.S_TDATA;
        r_rx_addr <= r_count;
        r_count   <= r_count + ADDR_W'(1);
      end
      if (w_load_hdr) begin
        r_count       <= '0;
        r_shadow_ip   <= s_if.HDR_SRC_IP;
        r_shadow_mac  <= s_if.HDR_SRC_MAC;
        r_shadow_port <= s_if.HDR_SRC_UDP_PORT;
      end
      if (w_latch_src) begin
        r_src_ip   <= r_shadow_ip;
        r_src_mac  <= r_shadow_mac;
        r_src_port <= r_shadow_port;
      end
      if (w_drop_inc && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign RX_DATA            = r_rx_data;
  assign RX_ADDR            = r_rx_addr;
  assign RX_EN              = r_rx_en;
  assign SRC_IP_ADDRESS_IP  = r_src_ip;
  assign SRC_MAC_ADDRESS_IP = r_src_mac;
  assign SRC_UDP_PORT_IP    = r_src_port;
  assign FRAME_READY        = (r_state == ST_READY);
  assign DROP_COUNT         = r_drop_count;

endmodule

// File: tb/tb_udp_rx_to_buff.sv
// Directed bench for udp_rx_to_buff: good, wrong-port, short, long, gapped, back-pressured and reset-interrupted frames.
module tb_udp_rx_to_buff;
  localparam int N  = 784;
  localparam int AW = 10;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b0;
  logic          BUFF_DONE = 1'b0;
  logic [7:0]    RX_DATA;
  logic [AW-1:0] RX_ADDR;
  logic          RX_EN;
  logic [0:31]   SRC_IP_ADDRESS_IP;
  logic [0:47]   SRC_MAC_ADDRESS_IP;
  logic [0:15]   SRC_UDP_PORT_IP;
  logic          FRAME_READY;
  logic [15:0]   DROP_COUNT;

  udp_rx_to_buff_if rx_if();

  udp_rx_to_buff #(
    .USER_DATA_BYTES(N),
    .ADDR_W         (AW),
    .LISTEN_PORT    (16'd9000)
  ) dut (
    .ACLK              (ACLK),
    .ARESET            (ARESET),
    .s_if              (rx_if),
    .RX_DATA           (RX_DATA),
    .RX_ADDR           (RX_ADDR),
    .RX_EN             (RX_EN),
    .SRC_IP_ADDRESS_IP (SRC_IP_ADDRESS_IP),
    .SRC_MAC_ADDRESS_IP(SRC_MAC_ADDRESS_IP),
    .SRC_UDP_PORT_IP   (SRC_UDP_PORT_IP),
    .FRAME_READY       (FRAME_READY),
    .BUFF_DONE         (BUFF_DONE),
    .DROP_COUNT        (DROP_COUNT)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int wr_base = 0;
  int order_err = 0;
  int fr_cnt = 0;
  int fr_cyc = 0;
  int last_wr_cyc = 0;
  logic [AW-1:0] last_addr = '0;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Writes must arrive in address order from 0 within a frame, carrying byte index mod 256.
  always @(negedge ACLK) begin
    if (RX_EN === 1'b1) begin
      if (RX_ADDR !== AW'(wr_cnt - wr_base) || RX_DATA !== RX_ADDR[7:0]) order_err = order_err + 1;
      last_addr   = RX_ADDR;
      last_wr_cyc = cyc;
      wr_cnt      = wr_cnt + 1;
    end
    if (FRAME_READY === 1'b1) begin
      fr_cnt = fr_cnt + 1;
      fr_cyc = cyc;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_header(input logic [15:0] dst, input logic [31:0] ip,
                             input logic [47:0] mac, input logic [15:0] sport);
    int t;
    rx_if.HDR_DST_UDP_PORT = dst;
    rx_if.HDR_SRC_IP       = ip;
    rx_if.HDR_SRC_MAC      = mac;
    rx_if.HDR_SRC_UDP_PORT = sport;
    rx_if.HDR_VALID        = 1'b1;
    t = 0;
    while (rx_if.HDR_READY !== 1'b1 && t < 5000) begin
      @(negedge ACLK);
      t++;
    end
    if (rx_if.HDR_READY !== 1'b1) check_eq("hdr_ready_timeout", 64'(rx_if.HDR_READY), 64'd1);
    @(negedge ACLK);
    rx_if.HDR_VALID = 1'b0;
  endtask

  // Sends bytes 0..n-1 (value = index mod 256); TLAST on index last_idx (-1 for none).
  task automatic send_bytes(input int n, input int last_idx, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      rx_if.S_TDATA  = 8'(i);
      rx_if.S_TLAST  = (i == last_idx);
      rx_if.S_TVALID = 1'b1;
      t = 0;
      while (rx_if.S_TREADY !== 1'b1 && t < 5000) begin
        @(negedge ACLK);
        t++;
      end
      if (rx_if.S_TREADY !== 1'b1) begin
        check_eq("tready_timeout", 64'(rx_if.S_TREADY), 64'd1);
        rx_if.S_TVALID = 1'b0;
        rx_if.S_TLAST  = 1'b0;
        return;
      end
      @(negedge ACLK);
      rx_if.S_TVALID = 1'b0;
      rx_if.S_TLAST  = 1'b0;
      if (gaps) @(negedge ACLK);
    end
  endtask

  task automatic buff_done_pulse();
    BUFF_DONE = 1'b1;
    @(negedge ACLK);
    BUFF_DONE = 1'b0;
  endtask

  int w0, f0, stall_ready;

  initial begin
    rx_if.HDR_VALID = 1'b0;
    rx_if.HDR_SRC_IP = '0;
    rx_if.HDR_SRC_MAC = '0;
    rx_if.HDR_SRC_UDP_PORT = '0;
    rx_if.HDR_DST_UDP_PORT = '0;
    rx_if.S_TDATA = '0;
    rx_if.S_TVALID = 1'b0;
    rx_if.S_TLAST = 1'b0;

    repeat (3) @(negedge ACLK);
    check_eq("rst_hdr_ready", 64'(rx_if.HDR_READY), 64'd0);
    check_eq("rst_tready", 64'(rx_if.S_TREADY), 64'd0);
    check_eq("rst_rx_en", 64'(RX_EN), 64'd0);
    check_eq("rst_frame_ready", 64'(FRAME_READY), 64'd0);
    check_eq("rst_drop_count", 64'(DROP_COUNT), 64'd0);
    check_eq("rst_src_ip", 64'(SRC_IP_ADDRESS_IP), 64'd0);
    ARESET = 1'b1;
    @(negedge ACLK);
    check_eq("idle_hdr_ready", 64'(rx_if.HDR_READY), 64'd1);

    // Nominal good frame
    w0 = wr_cnt; f0 = fr_cnt; wr_base = wr_cnt;
    send_header(16'd9000, 32'h0A000002, 48'h020000000001, 16'd1234);
    send_bytes(N, N - 1, 1'b0);
    repeat (2) @(negedge ACLK);
    $display("frame nominal: writes=%0d frame_ready=%0d drops=%0d", wr_cnt - w0, fr_cnt - f0, DROP_COUNT);
    check_eq("t1_writes", 64'(wr_cnt - w0), 64'(N));
    check_eq("t1_order", 64'(order_err), 64'd0);
    check_eq("t1_last_addr", 64'(last_addr), 64'(N - 1));
    check_eq("t1_frame_ready", 64'(fr_cnt - f0), 64'd1);
    check_eq("t1_ready_with_last_write", 64'(fr_cyc), 64'(last_wr_cyc));
    check_eq("t1_src_ip", 64'(SRC_IP_ADDRESS_IP), 64'h0A000002);
    check_eq("t1_src_mac", 64'(SRC_MAC_ADDRESS_IP), 64'h020000000001);
    check_eq("t1_src_port", 64'(SRC_UDP_PORT_IP), 64'd1234);
    check_eq("t1_drops", 64'(DROP_COUNT), 64'd0);
    check_eq("t1_wait_hdr_ready", 64'(rx_if.HDR_READY), 64'd0);
    buff_done_pulse();
    check_eq("t1_done_hdr_ready", 64'(rx_if.HDR_READY), 64'd1);

    // Wrong destination port
    w0 = wr_cnt; f0 = fr_cnt; wr_base = wr_cnt;
    send_header(16'd80, 32'h0B000009, 48'h0B0000000009, 16'd4321);
    send_bytes(N, N - 1, 1'b0);
    repeat (2) @(negedge ACLK);
    $display("frame wrong_port: writes=%0d frame_ready=%0d drops=%0d", wr_cnt - w0, fr_cnt - f0, DROP_COUNT);
    check_eq("t2_writes", 64'(wr_cnt - w0), 64'd0);
    check_eq("t2_frame_ready", 64'(fr_cnt - f0), 64'd0);
    check_eq("t2_drops", 64'(DROP_COUNT), 64'd1);
    check_eq("t2_src_ip_kept", 64'(SRC_IP_ADDRESS_IP), 64'h0A000002);
    check_eq("t2_src_port_kept", 64'(SRC_UDP_PORT_IP), 64'd1234);
    check_eq("t2_idle", 64'(rx_if.HDR_READY), 64'd1);

    // Short frame: TLAST at byte 500
    w0 = wr_cnt; f0 = fr_cnt; wr_base = wr_cnt;
    send_header(16'd9000, 32'h0C000001, 48'h0C0000000001, 16'd77);
    send_bytes(501, 500, 1'b0);
    repeat (2) @(negedge ACLK);
    $display("frame short: writes=%0d frame_ready=%0d drops=%0d", wr_cnt - w0, fr_cnt - f0, DROP_COUNT);
    check_eq("t3s_writes", 64'(wr_cnt - w0), 64'd501);
    check_eq("t3s_frame_ready", 64'(fr_cnt - f0), 64'd0);
    check_eq("t3s_drops", 64'(DROP_COUNT), 64'd2);
    check_eq("t3s_src_ip_kept", 64'(SRC_IP_ADDRESS_IP), 64'h0A000002);
    check_eq("t3s_idle", 64'(rx_if.HDR_READY), 64'd1);

    // Long frame: 800 bytes
    w0 = wr_cnt; f0 = fr_cnt; wr_base = wr_cnt;
    send_header(16'd9000, 32'h0D000001, 48'h0D0000000001, 16'd88);
    send_bytes(800, 799, 1'b0);
    repeat (2) @(negedge ACLK);
    $display("frame long: writes=%0d frame_ready=%0d drops=%0d", wr_cnt - w0, fr_cnt - f0, DROP_COUNT);
    check_eq("t3l_writes", 64'(wr_cnt - w0), 64'(N));
    check_eq("t3l_last_addr", 64'(last_addr), 64'(N - 1));
    check_eq("t3l_frame_ready", 64'(fr_cnt - f0), 64'd0);
    check_eq("t3l_drops", 64'(DROP_COUNT), 64'd3);
    check_eq("t3l_order", 64'(order_err), 64'd0);
    check_eq("t3l_idle", 64'(rx_if.HDR_READY), 64'd1);

    // Good frame with TVALID toggling every cycle
    w0 = wr_cnt; f0 = fr_cnt; wr_base = wr_cnt;
    send_header(16'd9000, 32'h0A000003, 48'h020000000003, 16'd1003);
    send_bytes(N, N - 1, 1'b1);
    repeat (2) @(negedge ACLK);
    $display("frame gaps: writes=%0d frame_ready=%0d drops=%0d", wr_cnt - w0, fr_cnt - f0, DROP_COUNT);
    check_eq("t5_writes", 64'(wr_cnt - w0), 64'(N));
    check_eq("t5_order", 64'(order_err), 64'd0);
    check_eq("t5_frame_ready", 64'(fr_cnt - f0), 64'd1);
    check_eq("t5_ready_with_last_write", 64'(fr_cyc), 64'(last_wr_cyc));
    check_eq("t5_src_ip", 64'(SRC_IP_ADDRESS_IP), 64'h0A000003);
    check_eq("t5_drops", 64'(DROP_COUNT), 64'd3);

    // Back-pressure: next header offered while waiting for BUFF_DONE
    w0 = wr_cnt; f0 = fr_cnt;
    rx_if.HDR_DST_UDP_PORT = 16'd9000;
    rx_if.HDR_SRC_IP       = 32'h0A000004;
    rx_if.HDR_SRC_MAC      = 48'h020000000004;
    rx_if.HDR_SRC_UDP_PORT = 16'd1004;
    rx_if.HDR_VALID        = 1'b1;
    stall_ready = 0;
    repeat (6) begin
      @(negedge ACLK);
      if (rx_if.HDR_READY !== 1'b0) stall_ready++;
    end
    check_eq("t4_stalled_ready", 64'(stall_ready), 64'd0);
    check_eq("t4_stalled_writes", 64'(wr_cnt - w0), 64'd0);
    check_eq("t4_stalled_src_ip", 64'(SRC_IP_ADDRESS_IP), 64'h0A000003);
    buff_done_pulse();
    check_eq("t4_ready_after_done", 64'(rx_if.HDR_READY), 64'd1);
    wr_base = wr_cnt;
    send_header(16'd9000, 32'h0A000004, 48'h020000000004, 16'd1004);
    send_bytes(N, N - 1, 1'b0);
    repeat (2) @(negedge ACLK);
    $display("frame backpressure: writes=%0d frame_ready=%0d drops=%0d", wr_cnt - w0, fr_cnt - f0, DROP_COUNT);
    check_eq("t4_writes", 64'(wr_cnt - w0), 64'(N));
    check_eq("t4_frame_ready", 64'(fr_cnt - f0), 64'd1);
    check_eq("t4_src_ip", 64'(SRC_IP_ADDRESS_IP), 64'h0A000004);
    check_eq("t4_order", 64'(order_err), 64'd0);
    buff_done_pulse();

    // Reset in the middle of a good frame
    w0 = wr_cnt; f0 = fr_cnt; wr_base = wr_cnt;
    send_header(16'd9000, 32'h0A000005, 48'h020000000005, 16'd1005);
    send_bytes(300, -1, 1'b0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check_eq("t6_hdr_ready", 64'(rx_if.HDR_READY), 64'd0);
    check_eq("t6_tready", 64'(rx_if.S_TREADY), 64'd0);
    check_eq("t6_rx_en", 64'(RX_EN), 64'd0);
    check_eq("t6_rx_addr", 64'(RX_ADDR), 64'd0);
    check_eq("t6_rx_data", 64'(RX_DATA), 64'd0);
    check_eq("t6_src_ip", 64'(SRC_IP_ADDRESS_IP), 64'd0);
    check_eq("t6_src_mac", 64'(SRC_MAC_ADDRESS_IP), 64'd0);
    check_eq("t6_drops", 64'(DROP_COUNT), 64'd0);
    check_eq("t6_frame_ready", 64'(FRAME_READY), 64'd0);
    ARESET = 1'b1;
    #1;
    check_eq("t6_idle_after_reset", 64'(rx_if.HDR_READY), 64'd1);
    repeat (3) @(negedge ACLK);
    $display("frame reset_mid: writes=%0d frame_ready=%0d drops=%0d", wr_cnt - w0, fr_cnt - f0, DROP_COUNT);
    check_eq("t6_writes_before_reset", 64'(wr_cnt - w0), 64'd300);
    check_eq("t6_no_frame_ready", 64'(fr_cnt - f0), 64'd0);

    w0 = wr_cnt; f0 = fr_cnt; wr_base = wr_cnt;
    send_header(16'd9000, 32'h0A000006, 48'h020000000006, 16'd1006);
    send_bytes(N, N - 1, 1'b0);
    repeat (2) @(negedge ACLK);
    $display("frame after_reset: writes=%0d frame_ready=%0d drops=%0d", wr_cnt - w0, fr_cnt - f0, DROP_COUNT);
    check_eq("t6b_writes", 64'(wr_cnt - w0), 64'(N));
    check_eq("t6b_frame_ready", 64'(fr_cnt - f0), 64'd1);
    check_eq("t6b_src_ip", 64'(SRC_IP_ADDRESS_IP), 64'h0A000006);
    check_eq("t6b_src_port", 64'(SRC_UDP_PORT_IP), 64'd1006);
    check_eq("t6b_drops", 64'(DROP_COUNT), 64'd0);
    check_eq("t6b_order", 64'(order_err), 64'd0);
    buff_done_pulse();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
